// File: rtl/supply_rail_monitor.sv
// supply_rail_monitor
// Multi-rail power-good monitor. Each rail's signed microvolt sample drives
// a debounced, hysteretic OFF / PEND_ON / ON / PEND_OFF state machine. The
// block reports per-rail power-good, on/off event pulses, sticky overvoltage
// flags and a registered all-rails-on summary.
module supply_rail_monitor #(
    parameter int NUM_CH    = 4,
    parameter int VW        = 32,
    parameter int ON_MIN_UV = 810000,
    parameter int ON_MAX_UV = 1320000,
    parameter int HYST_UV   = 20000,
    parameter int DEBOUNCE  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_valid,
    input  logic [NUM_CH*VW-1:0] voltage_uv,
    input  logic [NUM_CH-1:0]    ov_clr,
    output logic [NUM_CH-1:0]    full_on,
    output logic [NUM_CH*2-1:0]  ch_state,
    output logic [NUM_CH-1:0]    on_evt,
    output logic [NUM_CH-1:0]    off_evt,
    output logic [NUM_CH-1:0]    ov_sticky,
    output logic                 all_on
);

    // Debounce counter only needs to reach DEBOUNCE.
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] DEB_C = CW'(DEBOUNCE);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    // Thresholds carry one extra bit so that MAX+HYST cannot wrap.
    localparam logic signed [VW:0] MIN_T  = (VW+1)'(ON_MIN_UV);
    localparam logic signed [VW:0] MAX_T  = (VW+1)'(ON_MAX_UV);
    localparam logic signed [VW:0] HYST_T = (VW+1)'(HYST_UV);
    localparam logic signed [VW:0] MIN_H  = MIN_T - HYST_T;
    localparam logic signed [VW:0] MAX_H  = MAX_T + HYST_T;

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_PEND_ON  = 2'd1,
        ST_ON       = 2'd2,
        ST_PEND_OFF = 2'd3
    } state_t;

    logic all_on_q;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        state_t           state_q, state_d;
        logic [CW-1:0]    cnt_q, cnt_d;
        logic             full_on_q, full_on_d;
        logic             on_evt_q, off_evt_q;
        logic             ov_q, ov_d;
        logic signed [VW:0] v;
        logic             in_win, out_hyst, over;

        // Sign-extend so negative samples compare as below the minimum.
        assign v        = {voltage_uv[gi*VW+VW-1], voltage_uv[gi*VW +: VW]};
        assign in_win   = (v >= MIN_T) && (v <= MAX_T);
        assign over     = (v > MAX_H);
        assign out_hyst = (v < MIN_H) || over;

        // Next-state, debounce count and sticky flag; all hold on invalid cycles.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            ov_d    = ov_q;
            if (sample_valid) begin
                ov_d = over | (ov_q & ~ov_clr[gi]);
                case (state_q)
                    ST_OFF: begin
                        if (in_win) begin
                            if (DEBOUNCE == 1) begin
                                state_d = ST_ON;
                                cnt_d   = '0;
                            end else begin
                                state_d = ST_PEND_ON;
                                cnt_d   = ONE_C;
                            end
                        end
                    end
                    ST_PEND_ON: begin
                        if (!in_win) begin
                            state_d = ST_OFF;
                            cnt_d   = '0;
                        end else if (cnt_q + ONE_C == DEB_C) begin
                            state_d = ST_ON;
                            cnt_d   = '0;
                        end else begin
                            cnt_d   = cnt_q + ONE_C;
                        end
                    end
                    ST_ON: begin
                        if (out_hyst) begin
                            if (DEBOUNCE == 1) begin
                                state_d = ST_OFF;
                                cnt_d   = '0;
                            end else begin
                                state_d = ST_PEND_OFF;
                                cnt_d   = ONE_C;
                            end
                        end
                    end
                    default: begin
                        if (!out_hyst) begin
                            state_d = ST_ON;
                            cnt_d   = '0;
                        end else if (cnt_q + ONE_C == DEB_C) begin
                            state_d = ST_OFF;
                            cnt_d   = '0;
                        end else begin
                            cnt_d   = cnt_q + ONE_C;
                        end
                    end
                endcase
            end
            // A rail counts as on until it has been debounced off.
            full_on_d = (state_d == ST_ON) || (state_d == ST_PEND_OFF);
        end

        // Channel state, power-good and edge pulses, all registered.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= ST_OFF;
                cnt_q     <= '0;
                full_on_q <= 1'b0;
                on_evt_q  <= 1'b0;
                off_evt_q <= 1'b0;
                ov_q      <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                full_on_q <= full_on_d;
                on_evt_q  <= full_on_d & ~full_on_q;
                off_evt_q <= ~full_on_d & full_on_q;
                ov_q      <= ov_d;
            end
        end

        assign full_on[gi]           = full_on_q;
        assign on_evt[gi]            = on_evt_q;
        assign off_evt[gi]           = off_evt_q;
        assign ov_sticky[gi]         = ov_q;
        assign ch_state[gi*2 +: 2]   = state_q;
    end

    // Summary flag, one cycle behind the per-rail power-good bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            all_on_q <= 1'b0;
        end else begin
            all_on_q <= &full_on;
        end
    end

    assign all_on = all_on_q;

endmodule
